// File: rtl/audio_gain_sequencer_pkg.sv
//============================================================================
// audio_pkg: shared widths, sequencer state encoding and gain-ramp helper.
// Rev 1.0
//============================================================================
`default_nettype none

package audio_pkg;

    localparam int GAIN_W   = 8;
    localparam int SAMPLE_W = 16;
    localparam int ROM_W    = 16;
    localparam int SCALED_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR0 = 3'd1,
        S_DATA0 = 3'd2,
        S_ADDR1 = 3'd3,
        S_DATA1 = 3'd4,
        S_OUT   = 3'd5
    } state_e;

    // Moves idx one step toward target, landing exactly on target when the
    // remaining gap is no larger than the step (never wraps past 0 or 255).
    function automatic logic [GAIN_W-1:0] ramp_sat(
        input logic [GAIN_W-1:0] idx,
        input logic [GAIN_W-1:0] target,
        input logic [GAIN_W-1:0] step
    );
        logic [GAIN_W-1:0] gap;
        ramp_sat = idx;
        gap      = '0;
        if (idx < target) begin
            gap      = target - idx;
            ramp_sat = (gap <= step) ? target : (idx + step);
        end else if (idx > target) begin
            gap      = idx - target;
            ramp_sat = (gap <= step) ? target : (idx - step);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/audio_gain_sequencer_if.sv
//============================================================================
// audio_gain_sequencer_if: sample, volume, ROM and scaled-output signals.
// Rev 1.0
//============================================================================
`default_nettype none

interface audio_gain_sequencer_if import audio_pkg::*; ();

    logic                Sample_Strobe;
    logic                Mute;
    logic [GAIN_W-1:0]   Volume_0;
    logic [GAIN_W-1:0]   Volume_1;
    logic [SAMPLE_W-1:0] Audio_0;
    logic [SAMPLE_W-1:0] Audio_1;
    logic [GAIN_W-1:0]   Rom_Address;
    logic [ROM_W-1:0]    Rom_Data;
    logic [SCALED_W-1:0] Scaled_0;
    logic [SCALED_W-1:0] Scaled_1;
    logic                Scaled_Valid;
    logic                Busy;
    logic                Overrun;

    modport slave (
        input  Sample_Strobe, Mute, Volume_0, Volume_1, Audio_0, Audio_1, Rom_Data,
        output Rom_Address, Scaled_0, Scaled_1, Scaled_Valid, Busy, Overrun
    );

    modport master (
        output Sample_Strobe, Mute, Volume_0, Volume_1, Audio_0, Audio_1, Rom_Data,
        input  Rom_Address, Scaled_0, Scaled_1, Scaled_Valid, Busy, Overrun
    );

endinterface

`default_nettype wire

// File: rtl/audio_gain_sequencer_gain_ramp.sv
//============================================================================
// gain_ramp: per-channel gain index register with saturating ramp step.
// Rev 1.0
//============================================================================
`default_nettype none

module gain_ramp import audio_pkg::*; #(
    parameter int RAMP_STEP = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_step_en,
    input  wire logic [GAIN_W-1:0] i_target,
    output logic      [GAIN_W-1:0] o_index,
    output logic      [GAIN_W-1:0] o_index_next
);

    localparam logic [GAIN_W-1:0] c_STEP = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0] r_index_q;
    logic [GAIN_W-1:0] w_index_d;

    always_comb begin
        w_index_d = r_index_q;
        if (i_step_en) begin
            w_index_d = ramp_sat(r_index_q, i_target, c_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index_q <= '0;
        end else begin
            r_index_q <= w_index_d;
        end
    end

    assign o_index      = r_index_q;
    assign o_index_next = w_index_d;

endmodule

`default_nettype wire

// File: rtl/audio_gain_sequencer.sv
//============================================================================
// audio_gain_sequencer: time-shares one volume ROM port and one multiplier
// between two audio channels once per sample strobe.  Rev 1.0
//============================================================================
`default_nettype none

module audio_gain_sequencer import audio_pkg::*; #(
    parameter int RAMP_STEP = 1,
    parameter bit MUTE_ZERO = 1'b1
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    audio_gain_sequencer_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_ADDR0 = S_ADDR0;
    localparam logic [2:0] ST_DATA0 = S_DATA0;
    localparam logic [2:0] ST_ADDR1 = S_ADDR1;
    localparam logic [2:0] ST_DATA1 = S_DATA1;
    localparam logic [2:0] ST_OUT   = S_OUT;

    logic [2:0]          r_state_q,    w_state_d;
    logic                r_sign_0_q,   w_sign_0_d;
    logic                r_sign_1_q,   w_sign_1_d;
    logic [SAMPLE_W-1:0] r_abs_0_q,    w_abs_0_d;
    logic [SAMPLE_W-1:0] r_abs_1_q,    w_abs_1_d;
    logic [SCALED_W-1:0] r_prod_0_q,   w_prod_0_d;
    logic [SCALED_W-1:0] r_scaled_0_q, w_scaled_0_d;
    logic [SCALED_W-1:0] r_scaled_1_q, w_scaled_1_d;
    logic [GAIN_W-1:0]   r_rom_addr_q, w_rom_addr_d;
    logic                r_overrun_q,  w_overrun_d;

    logic                w_accept;
    logic [GAIN_W-1:0]   w_target_0, w_target_1;
    logic [GAIN_W-1:0]   w_index_0, w_index_1;
    logic [GAIN_W-1:0]   w_index_next_0, w_index_next_1;
    logic [SAMPLE_W-1:0] w_mul_a;
    logic [SCALED_W-1:0] w_mul_p;
    logic                w_force_zero;

    assign w_accept   = (r_state_q == ST_IDLE) && bus.Sample_Strobe;
    assign w_target_0 = bus.Mute ? '0 : bus.Volume_0;
    assign w_target_1 = bus.Mute ? '0 : bus.Volume_1;

    gain_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_0 (
        .clk          (Clk),
        .rst          (Reset),
        .i_step_en    (w_accept),
        .i_target     (w_target_0),
        .o_index      (w_index_0),
        .o_index_next (w_index_next_0)
    );

    gain_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_1 (
        .clk          (Clk),
        .rst          (Reset),
        .i_step_en    (w_accept),
        .i_target     (w_target_1),
        .o_index      (w_index_1),
        .o_index_next (w_index_next_1)
    );

    // Single shared multiplier: channel 1 operand only while in DATA1.
    assign w_mul_a = (r_state_q == ST_DATA1) ? r_abs_1_q : r_abs_0_q;
    assign w_mul_p = SCALED_W'(w_mul_a) * SCALED_W'(bus.Rom_Data);

    assign w_force_zero = MUTE_ZERO && bus.Mute && (w_index_0 == '0) && (w_index_1 == '0);

    always_comb begin
        w_state_d    = r_state_q;
        w_sign_0_d   = r_sign_0_q;
        w_sign_1_d   = r_sign_1_q;
        w_abs_0_d    = r_abs_0_q;
        w_abs_1_d    = r_abs_1_q;
        w_prod_0_d   = r_prod_0_q;
        w_scaled_0_d = r_scaled_0_q;
        w_scaled_1_d = r_scaled_1_q;
        w_rom_addr_d = r_rom_addr_q;
        w_overrun_d  = r_overrun_q | (bus.Sample_Strobe && (r_state_q != ST_IDLE));

        case (r_state_q)
            ST_IDLE: begin
                if (bus.Sample_Strobe) begin
                    w_sign_0_d   = bus.Audio_0[SAMPLE_W-1];
                    w_sign_1_d   = bus.Audio_1[SAMPLE_W-1];
                    w_abs_0_d    = bus.Audio_0[SAMPLE_W-1] ? (~bus.Audio_0 + 16'd1) : bus.Audio_0;
                    w_abs_1_d    = bus.Audio_1[SAMPLE_W-1] ? (~bus.Audio_1 + 16'd1) : bus.Audio_1;
                    w_rom_addr_d = w_index_next_0;
                    w_state_d    = ST_ADDR0;
                end
            end
            ST_ADDR0: w_state_d = ST_DATA0;
            ST_DATA0: begin
                w_prod_0_d   = w_mul_p;
                w_rom_addr_d = w_index_1;
                w_state_d    = ST_ADDR1;
            end
            ST_ADDR1: w_state_d = ST_DATA1;
            ST_DATA1: begin
                // Both channels are written on the same edge so they change together.
                if (w_force_zero) begin
                    w_scaled_0_d = '0;
                    w_scaled_1_d = '0;
                end else begin
                    w_scaled_0_d = r_sign_0_q ? (SCALED_W'(0) - r_prod_0_q) : r_prod_0_q;
                    w_scaled_1_d = r_sign_1_q ? (SCALED_W'(0) - w_mul_p) : w_mul_p;
                end
                w_state_d = ST_OUT;
            end
            ST_OUT:  w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q    <= ST_IDLE;
            r_sign_0_q   <= 1'b0;
            r_sign_1_q   <= 1'b0;
            r_abs_0_q    <= '0;
            r_abs_1_q    <= '0;
            r_prod_0_q   <= '0;
            r_scaled_0_q <= '0;
            r_scaled_1_q <= '0;
            r_rom_addr_q <= '0;
            r_overrun_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_sign_0_q   <= w_sign_0_d;
            r_sign_1_q   <= w_sign_1_d;
            r_abs_0_q    <= w_abs_0_d;
            r_abs_1_q    <= w_abs_1_d;
            r_prod_0_q   <= w_prod_0_d;
            r_scaled_0_q <= w_scaled_0_d;
            r_scaled_1_q <= w_scaled_1_d;
            r_rom_addr_q <= w_rom_addr_d;
            r_overrun_q  <= w_overrun_d;
        end
    end

    assign bus.Rom_Address  = r_rom_addr_q;
    assign bus.Scaled_0     = r_scaled_0_q;
    assign bus.Scaled_1     = r_scaled_1_q;
    assign bus.Scaled_Valid = (r_state_q == ST_OUT);
    assign bus.Busy         = (r_state_q != ST_IDLE);
    assign bus.Overrun      = r_overrun_q;

endmodule

`default_nettype wire
